// File: rtl/oled_pkg.sv
// Shared constants for the SSD1306 SPI streamer: init ROM, address window, FSM states.
// The optional OLED_FRAME_PACING_EN build uses ST_IDLE between frames.
package oled_pkg;

    localparam int FRAME_BYTES = 1024;
    localparam int INIT_LEN    = 25;
    localparam int ADDR_LEN    = 6;

    localparam logic [7:0] ADDR_COL_CMD   = 8'h21;
    localparam logic [7:0] ADDR_COL_START = 8'h00;
    localparam logic [7:0] ADDR_COL_END   = 8'h7F;
    localparam logic [7:0] ADDR_PAGE_CMD  = 8'h22;
    localparam logic [7:0] ADDR_PAGE_START = 8'h00;
    localparam logic [7:0] ADDR_PAGE_END  = 8'h07;

    localparam logic [2:0] ST_RST_HOLD = 3'd0;
    localparam logic [2:0] ST_RST_WAIT = 3'd1;
    localparam logic [2:0] ST_INIT     = 3'd2;
    localparam logic [2:0] ST_ADDR     = 3'd3;
    localparam logic [2:0] ST_FETCH    = 3'd4;
    localparam logic [2:0] ST_PIX      = 3'd5;
    localparam logic [2:0] ST_IDLE     = 3'd6;

    function automatic logic [7:0] init_cmd(input logic [4:0] idx);
        case (idx)
            5'd0:  return 8'hAE;
            5'd1:  return 8'hD5;
            5'd2:  return 8'h80;
            5'd3:  return 8'hA8;
            5'd4:  return 8'h3F;
            5'd5:  return 8'hD3;
            5'd6:  return 8'h00;
            5'd7:  return 8'h40;
            5'd8:  return 8'h8D;
            5'd9:  return 8'h14;
            5'd10: return 8'h20;
            5'd11: return 8'h00;
            5'd12: return 8'hA1;
            5'd13: return 8'hC8;
            5'd14: return 8'hDA;
            5'd15: return 8'h12;
            5'd16: return 8'h81;
            5'd17: return 8'hCF;
            5'd18: return 8'hD9;
            5'd19: return 8'hF1;
            5'd20: return 8'hDB;
            5'd21: return 8'h40;
            5'd22: return 8'hA4;
            5'd23: return 8'hA6;
            5'd24: return 8'hAF;
            default: return 8'hE3;
        endcase
    endfunction

    function automatic logic [7:0] addr_cmd(input logic [2:0] idx);
        case (idx)
            3'd0: return ADDR_COL_CMD;
            3'd1: return ADDR_COL_START;
            3'd2: return ADDR_COL_END;
            3'd3: return ADDR_PAGE_CMD;
            3'd4: return ADDR_PAGE_START;
            3'd5: return ADDR_PAGE_END;
            default: return 8'hE3;
        endcase
    endfunction

endpackage

// File: rtl/oled_spi_streamer_spi_byte_tx.sv
// One SPI mode-0 byte: dc setup cycle, 16 SCLK half-periods with cs_n low,
// then a CLK_DIV-cycle cs_n gap before done pulses.
module spi_byte_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       dc_sel,
    output logic       sclk,
    output logic       mosi,
    output logic       dc,
    output logic       cs_n,
    output logic       done,
    output logic       busy
);

    localparam int DW = $clog2(CLK_DIV);

    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_SETUP = 2'd1;
    localparam logic [1:0] PH_SHIFT = 2'd2;
    localparam logic [1:0] PH_GAP   = 2'd3;

    logic [1:0]    phase;
    logic [DW-1:0] div;
    logic [3:0]    half;
    logic [7:0]    sh;
    logic [2:0]    nbit;

    assign busy = (phase != PH_IDLE);
    assign nbit = half[3:1] + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH_IDLE;
            div   <= '0;
            half  <= '0;
            sh    <= '0;
            sclk  <= 1'b0;
            mosi  <= 1'b0;
            dc    <= 1'b0;
            cs_n  <= 1'b1;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (phase)
                PH_IDLE: if (start) begin
                    sh    <= data;
                    dc    <= dc_sel;
                    phase <= PH_SETUP;
                end
                PH_SETUP: begin
                    cs_n  <= 1'b0;
                    mosi  <= sh[7];
                    half  <= '0;
                    div   <= '0;
                    phase <= PH_SHIFT;
                end
                PH_SHIFT: if (div == DW'(CLK_DIV - 1)) begin
                    div <= '0;
                    if (half == 4'd15) begin
                        sclk  <= 1'b0;
                        cs_n  <= 1'b1;
                        phase <= PH_GAP;
                    end else begin
                        half <= half + 4'd1;
                        sclk <= ~half[0];
                        // next bit goes out on the falling edge
                        if (half[0]) mosi <= sh[3'd7 - nbit];
                    end
                end else begin
                    div <= div + 1'b1;
                end
                PH_GAP: if (div == DW'(CLK_DIV - 1)) begin
                    div   <= '0;
                    done  <= 1'b1;
                    phase <= PH_IDLE;
                end else begin
                    div <= div + 1'b1;
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/oled_spi_streamer.sv
// SSD1306 128x64 streamer: panel reset, init list, then endless frames over SPI.
// Define OLED_FRAME_PACING_EN to space frame starts by at least FRAME_PERIOD cycles.
module oled_spi_streamer #(
    parameter int CLK_DIV      = 4,
    parameter int RST_CYCLES   = 1000,
    parameter int RST_WAIT     = 1000,
    parameter int FETCH_LAT    = 2,
    parameter int FRAME_PERIOD = 2500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    output logic [9:0] byte_counter,
    output logic       oled_sclk,
    output logic       oled_mosi,
    output logic       oled_dc,
    output logic       oled_cs_n,
    output logic       oled_res_n,
    output logic       init_done,
    output logic       frame_done
);

    import oled_pkg::*;

    logic [2:0]  state;
    logic [31:0] cnt;
    logic [4:0]  idx;
    logic        issued;
    logic [7:0]  pix;
    logic        tx_start;
    logic        tx_dc;
    logic        tx_done;
    logic        tx_busy;
    logic [7:0]  tx_byte;
    logic        sending;
`ifdef OLED_FRAME_PACING_EN
    logic [31:0] fcnt;
    logic        period_met;
    assign period_met = (fcnt >= 32'(FRAME_PERIOD - 1));
`endif

    assign sending  = (state == ST_INIT) || (state == ST_ADDR) || (state == ST_PIX);
    assign tx_start = sending && !issued && !tx_busy;

    always_comb begin
        tx_byte = 8'h00;
        tx_dc   = 1'b0;
        case (state)
            ST_INIT: tx_byte = init_cmd(idx);
            ST_ADDR: tx_byte = addr_cmd(idx[2:0]);
            ST_PIX: begin
                tx_byte = pix;
                tx_dc   = 1'b1;
            end
            default: tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RST_HOLD;
            cnt          <= '0;
            idx          <= '0;
            issued       <= 1'b0;
            pix          <= '0;
            byte_counter <= '0;
            oled_res_n   <= 1'b0;
            init_done    <= 1'b0;
            frame_done   <= 1'b0;
`ifdef OLED_FRAME_PACING_EN
            fcnt         <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (tx_start) issued <= 1'b1;
`ifdef OLED_FRAME_PACING_EN
            if (fcnt != '1) fcnt <= fcnt + 32'd1;
`endif
            case (state)
                ST_RST_HOLD: if (cnt == 32'(RST_CYCLES - 1)) begin
                    cnt        <= '0;
                    oled_res_n <= 1'b1;
                    state      <= ST_RST_WAIT;
                end else begin
                    cnt <= cnt + 32'd1;
                end
                ST_RST_WAIT: if (cnt == 32'(RST_WAIT - 1)) begin
                    cnt   <= '0;
                    idx   <= '0;
                    state <= ST_INIT;
                end else begin
                    cnt <= cnt + 32'd1;
                end
                ST_INIT: if (tx_done) begin
                    issued <= 1'b0;
                    if (idx == 5'(INIT_LEN - 1)) begin
                        idx       <= '0;
                        init_done <= 1'b1;
                        state     <= ST_ADDR;
`ifdef OLED_FRAME_PACING_EN
                        fcnt      <= '0;
`endif
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                ST_ADDR: if (tx_done) begin
                    issued <= 1'b0;
                    if (idx == 5'(ADDR_LEN - 1)) begin
                        idx   <= '0;
                        cnt   <= '0;
                        state <= ST_FETCH;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                ST_FETCH: if (cnt == 32'(FETCH_LAT - 1)) begin
                    cnt   <= '0;
                    pix   <= data_in;
                    state <= ST_PIX;
                end else begin
                    cnt <= cnt + 32'd1;
                end
                ST_PIX: if (tx_done) begin
                    issued <= 1'b0;
                    if (byte_counter == 10'(FRAME_BYTES - 1)) begin
                        byte_counter <= '0;
                        frame_done   <= 1'b1;
`ifdef OLED_FRAME_PACING_EN
                        if (period_met) begin
                            fcnt  <= '0;
                            state <= ST_ADDR;
                        end else begin
                            state <= ST_IDLE;
                        end
`else
                        state        <= ST_ADDR;
`endif
                    end else begin
                        byte_counter <= byte_counter + 10'd1;
                        cnt          <= '0;
                        state        <= ST_FETCH;
                    end
                end
`ifdef OLED_FRAME_PACING_EN
                ST_IDLE: if (period_met) begin
                    fcnt  <= '0;
                    state <= ST_ADDR;
                end
`endif
                default: state <= ST_RST_HOLD;
            endcase
        end
    end

    spi_byte_tx #(
        .CLK_DIV(CLK_DIV)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .start (tx_start),
        .data  (tx_byte),
        .dc_sel(tx_dc),
        .sclk  (oled_sclk),
        .mosi  (oled_mosi),
        .dc    (oled_dc),
        .cs_n  (oled_cs_n),
        .done  (tx_done),
        .busy  (tx_busy)
    );

endmodule
